// File: rtl/acq_trigger_packer_if.sv
// Bus bundle for the acquisition trigger/packer: LVDS beat input, capture
// configuration, downstream FIFO write port and capture status.
interface acq_trigger_packer_if;
  logic        [139:0] lvdsbits;
  logic                arm;
  logic          [7:0] triggertype;
  logic         [15:0] lengthtotake;
  logic signed  [11:0] lowerthresh;
  logic signed  [11:0] upperthresh;
  logic                fifo_wrfull;
  logic                fifo_wr;
  logic        [559:0] fifo_data;
  logic         [15:0] wordcount;
  logic                busy;
  logic                done;
  logic                overflow;
  logic          [3:0] trigphase;

  modport master (
    output lvdsbits, arm, triggertype, lengthtotake, lowerthresh, upperthresh, fifo_wrfull,
    input  fifo_wr, fifo_data, wordcount, busy, done, overflow, trigphase
  );

  modport slave (
    input  lvdsbits, arm, triggertype, lengthtotake, lowerthresh, upperthresh, fifo_wrfull,
    output fifo_wr, fifo_data, wordcount, busy, done, overflow, trigphase
  );
endinterface

// File: rtl/acq_trigger_packer.sv
// Acquisition trigger and packer: waits for an immediate, threshold or
// auto-timeout trigger on the registered LVDS beat stream, then packs four
// consecutive 10-sample beats into each 560-bit FIFO word.
module acq_trigger_packer #(
  parameter logic [31:0] AUTO_TIMEOUT = 32'd50000
) (
  input  logic                 clklvds,
  input  logic                 rstn,
  acq_trigger_packer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state_q, state_nxt;

  logic arm_s1, arm_s2, arm_d;
  logic sync_vld_p1, sync_vld_p2;
  logic arm_ok;
  logic arm_rise;

  logic [139:0] lvds_q;

  logic               auto_q;
  logic        [15:0] len_q;
  logic signed [11:0] lo_q;
  logic signed [11:0] up_q;

  logic [559:0] pack_q;
  logic   [1:0] beat_idx;
  logic  [31:0] tmo_q;
  logic  [31:0] tmo_nxt;
  logic  [15:0] wordcount_q;
  logic   [3:0] trigphase_q;
  logic         overflow_q;
  logic         fifo_wr_q;
  logic [559:0] fifo_data_q;

  logic         lo_hit;
  logic   [9:0] hi_vec;
  logic         hi_hit;
  logic   [3:0] hi_idx;
  logic [139:0] beat_pk;

  logic start, fire, forced, pack_en, write_en, drop, auto_fire;

  // Sample s is bit-interleaved across the beat: bit b lives at lvds[10*b + s].
  function automatic logic signed [11:0] sample_val(input logic [139:0] w, input int s);
    logic signed [11:0] v;
    v = '0;
    for (int b = 0; b < 12; b++) v[b] = w[10*b + s];
    return v;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  // Arm synchronizer; arm_ok is only granted once a genuine low level has
  // been seen through a filled synchronizer, so arm held high across reset
  // cannot masquerade as a rising edge.
  always_ff @(posedge clklvds or negedge rstn) begin
    if (!rstn) begin
      arm_s1      <= 1'b0;
      arm_s2      <= 1'b0;
      arm_d       <= 1'b0;
      sync_vld_p1 <= 1'b0;
      sync_vld_p2 <= 1'b0;
      arm_ok      <= 1'b0;
    end else begin
      arm_s1      <= bus.arm;
      arm_s2      <= arm_s1;
      arm_d       <= arm_s2;
      sync_vld_p1 <= 1'b1;
      sync_vld_p2 <= sync_vld_p1;
      if (sync_vld_p2 && !arm_s2) arm_ok <= 1'b1;
    end
  end

  assign arm_rise = arm_ok && arm_s2 && !arm_d;

  // Input stage: one register on the raw LVDS word; everything downstream uses lvds_q.
  always_ff @(posedge clklvds or negedge rstn) begin
    if (!rstn) lvds_q <= '0;
    else       lvds_q <= bus.lvdsbits;
  end

  // Per-sample threshold compares and the 14-bit {strobe, value} beat image.
  always_comb begin
    lo_hit  = 1'b0;
    hi_vec  = '0;
    beat_pk = '0;
    for (int s = 0; s < 10; s++) begin
      if (sample_val(lvds_q, s) < lo_q) lo_hit = 1'b1;
      if (sample_val(lvds_q, s) > up_q) hi_vec[s] = 1'b1;
      beat_pk[14*s +: 14] = {lvds_q[130+s], lvds_q[120+s], sample_val(lvds_q, s)};
    end
  end

  // Lowest sample index above the upper threshold.
  always_comb begin
    hi_idx = 4'd0;
    for (int s = 9; s >= 0; s--) begin
      if (hi_vec[s]) hi_idx = 4'(s);
    end
  end

  assign hi_hit    = |hi_vec;
  assign tmo_nxt   = sat_inc(tmo_q);
  assign auto_fire = auto_q && (tmo_nxt >= AUTO_TIMEOUT);

  // Next-state and strobe decode; arm low always aborts an active capture.
  always_comb begin
    state_nxt = state_q;
    start     = 1'b0;
    fire      = 1'b0;
    forced    = 1'b0;
    pack_en   = 1'b0;
    write_en  = 1'b0;
    drop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm_rise) begin
          start = 1'b1;
          if (bus.triggertype == 8'd1 || bus.triggertype == 8'd2) state_nxt = S_WAIT_LOW;
          else if (bus.lengthtotake == 16'd0)                       state_nxt = S_DONE;
          else                                                       state_nxt = S_CAPTURE;
        end
      end
      S_WAIT_LOW: begin
        if (!arm_s2) state_nxt = S_IDLE;
        else if (auto_fire) begin
          forced    = 1'b1;
          state_nxt = (len_q == 16'd0) ? S_DONE : S_CAPTURE;
        end else if (lo_hit) state_nxt = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (!arm_s2) state_nxt = S_IDLE;
        else if (hi_hit) begin
          fire      = 1'b1;
          state_nxt = (len_q == 16'd0) ? S_DONE : S_CAPTURE;
        end else if (auto_fire) begin
          forced    = 1'b1;
          state_nxt = (len_q == 16'd0) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (!arm_s2) state_nxt = S_IDLE;
        else begin
          pack_en = 1'b1;
          if (beat_idx == 2'd3) begin
            if (bus.fifo_wrfull) begin
              drop      = 1'b1;
              state_nxt = S_DONE;
            end else begin
              write_en = 1'b1;
              if (({1'b0, wordcount_q} + 17'd1) >= {1'b0, len_q}) state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (!arm_s2) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, beat position, counters, status and the FIFO write port.
  always_ff @(posedge clklvds or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      beat_idx    <= 2'd0;
      tmo_q       <= '0;
      wordcount_q <= 16'hFFFF;
      trigphase_q <= 4'd0;
      overflow_q  <= 1'b0;
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= '0;
    end else begin
      state_q   <= state_nxt;
      fifo_wr_q <= write_en;

      if (start || forced || state_nxt == S_IDLE) beat_idx <= 2'd0;
      else if (fire)                              beat_idx <= 2'd1;
      else if (pack_en)                           beat_idx <= beat_idx + 2'd1;

      if (start) tmo_q <= 32'd1;
      else if (state_q == S_WAIT_LOW || state_q == S_WAIT_HIGH) tmo_q <= tmo_nxt;

      if (state_nxt == S_IDLE) wordcount_q <= 16'hFFFF;
      else if (start)          wordcount_q <= 16'd0;
      else if (write_en)       wordcount_q <= wordcount_q + 16'd1;

      if (start)       trigphase_q <= 4'd0;
      else if (fire)   trigphase_q <= hi_idx;
      else if (forced) trigphase_q <= 4'hF;

      if (start)     overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;

      if (write_en) fifo_data_q <= {beat_pk, pack_q[419:0]};
    end
  end

  // Capture configuration and word assembly; pure data, no reset needed.
  always_ff @(posedge clklvds) begin
    if (start) begin
      auto_q <= (bus.triggertype == 8'd2);
      len_q  <= bus.lengthtotake;
      lo_q   <= bus.lowerthresh;
      up_q   <= bus.upperthresh;
    end
    if (fire)         pack_q[139:0] <= beat_pk;
    else if (pack_en) pack_q[140*beat_idx +: 140] <= beat_pk;
  end

  assign bus.busy      = (state_q == S_WAIT_LOW) || (state_q == S_WAIT_HIGH) || (state_q == S_CAPTURE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.fifo_wr   = fifo_wr_q;
  assign bus.fifo_data = fifo_data_q;
  assign bus.wordcount = wordcount_q;
  assign bus.overflow  = overflow_q;
  assign bus.trigphase = trigphase_q;

endmodule

// File: doc/acq_trigger_packer.md
ACQ_TRIGGER_PACKER -- requirements
Module: acq_trigger_packer

Interface
REQ-001 Parameter AUTO_TIMEOUT, default 32'd50000, auto-trigger timeout in clklvds cycles for triggertype 2.
REQ-002 clklvds  input  1  sample clock; all logic on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 lvdsbits  input  140  deserialized ADC word from the LVDS receiver.
REQ-005 arm  input  1  capture request level, driven from the clk domain.
REQ-006 triggertype  input  8  0 = immediate, 1 = threshold, 2 = threshold with auto timeout; quasi-static.
REQ-007 lengthtotake  input  16  FIFO words to write per capture; quasi-static.
REQ-008 lowerthresh, upperthresh  input  12 each  signed threshold levels; quasi-static.
REQ-009 fifo_wrfull  input  1  downstream FIFO full flag.
REQ-010 fifo_wr  output  1  single-cycle FIFO write strobe.
REQ-011 fifo_data  output  560  packed 40-sample word.
REQ-012 wordcount  output  16  words written in the current capture; 16'hFFFF when IDLE.
REQ-013 busy, done, overflow  output  1 each  status flags.
REQ-014 trigphase  output  4  sample index (0-9) within the beat that fired the trigger.

Function
REQ-015 arm SHALL pass through a 2-flop synchronizer; a capture starts only on a synchronized 0->1 edge.
REQ-016 triggertype, lengthtotake and both thresholds SHALL be latched on that edge and held until IDLE is re-entered.
REQ-017 lvdsbits SHALL be registered once (lvds_q, 1 cycle latency). Every compare and every packing step SHALL use lvds_q.
REQ-018 Sample s (0-9) value = {lvds_q[110+s], lvds_q[100+s], ..., lvds_q[10+s], lvds_q[s]}, MSB first, signed 12-bit.
REQ-019 Sample s clock strobe = {lvds_q[130+s], lvds_q[120+s]}.
REQ-020 States: IDLE, WAIT_LOW, WAIT_HIGH, CAPTURE, DONE.
REQ-021 IDLE, on the arm edge:
- triggertype 0: go to CAPTURE.
- triggertype 1 or 2: go to WAIT_LOW.
- any other value: treated as 0.
REQ-022 WAIT_LOW -> WAIT_HIGH when any of the 10 samples in the beat is strictly below lowerthresh.
REQ-023 WAIT_HIGH -> CAPTURE when any sample is strictly above upperthresh; trigphase = lowest such index.
REQ-024 Type 2: a timeout counter starts at the arm edge. On reaching AUTO_TIMEOUT while in WAIT_LOW or WAIT_HIGH, the state SHALL force CAPTURE and set trigphase = 4'hF.
REQ-025 The beat that fires the trigger (or, for type 0 / forced triggers, the beat in the first CAPTURE cycle) SHALL be beat 0 of the first word.
REQ-026 Packing: 4 consecutive beats form one word. Beat k, sample s occupies fifo_data[14*(10k+s) +: 14] = {strobe, value}.
REQ-027 fifo_wr SHALL pulse for 1 cycle, with fifo_data stable, in the cycle after beat 3 is registered; wordcount increments in the same cycle.
REQ-028 Beats SHALL be packed continuously with no gaps: exactly one write per 4 cycles.
REQ-029 Capture stops after lengthtotake writes and the state goes to DONE.
REQ-030 lengthtotake = 0: the trigger SHALL still be awaited, then go directly to DONE with zero writes.
REQ-031 If fifo_wrfull = 1 in a write cycle:
- the word SHALL be dropped (no fifo_wr);
- overflow is set and stays sticky until the next arm edge;
- the state goes to DONE.
REQ-032 DONE: done = 1, busy = 0, wordcount held. Transition to IDLE when synchronized arm = 0.
REQ-033 arm falling while in WAIT_LOW, WAIT_HIGH or CAPTURE SHALL abort to IDLE. A partially packed word is discarded and never written.
REQ-034 busy = 1 in WAIT_LOW, WAIT_HIGH and CAPTURE; 0 otherwise.
REQ-035 The timeout counter SHALL saturate and never wrap. wordcount SHALL never exceed lengthtotake.

Reset
REQ-036 rstn low SHALL asynchronously force:
- state IDLE;
- fifo_wr = 0, fifo_data = 0;
- wordcount = 16'hFFFF;
- busy = 0, done = 0, overflow = 0;
- trigphase = 0;
- both synchronizer flops, lvds_q, and all counters = 0.
REQ-037 Reset asserted mid-capture SHALL drop any partial word.
REQ-038 After rstn release, arm already high SHALL NOT start a capture until arm goes low and then high again.

Verification
REQ-039 Immediate: type 0, length 3, arm rising with beat pattern incrementing -> 3 fifo_wr pulses 4 cycles apart, beats packed in order, then done = 1.
REQ-040 Threshold: type 1, thresh -10/+10, sample 3 = -20, then a later beat with sample 7 = +30 -> trigger on that beat, trigphase = 7, and that beat in fifo_data[0 +: 140].
REQ-041 Auto: type 2, AUTO_TIMEOUT = 100, flat zero input -> CAPTURE entered exactly 100 cycles after the synchronized edge, trigphase = 4'hF.
REQ-042 Overflow: fifo_wrfull = 1 at the second write -> 1 write only, overflow = 1, wordcount = 1, DONE.
REQ-043 Abort: arm drops after 2 beats of the first word -> no fifo_wr, IDLE, wordcount = 16'hFFFF.
REQ-044 Reset mid-capture, then release with arm high -> no capture until arm is toggled low then high.
